// File: rtl/locked_pattern_fsm.sv
// locked_pattern_fsm: keyed pattern matcher with a decoy chain and a hit-suppression payload.
module locked_pattern_fsm #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int KEY_W = 2,
  parameter logic [KEY_W-1:0] KEY_VAL = 2'b10,
  parameter logic [DEPTH*DATA_W-1:0] PATTERN = 32'hD4C3B2A1,
  parameter logic [DATA_W-1:0] CODE = 8'h5A,
  parameter bit TROJAN_EN = 1'b1,
  parameter int TRIG_LIMIT = 5,
  parameter int CNT_W = 8,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_vld,
  input  logic [DATA_W-1:0] din,
  input  logic [KEY_W-1:0]  key,
  output logic              hit,
  output logic [DATA_W-1:0] hit_code,
  output logic [SW-1:0]     stage,
  output logic              in_decoy,
  output logic [CNT_W-1:0]  hit_cnt
);
  typedef enum logic [1:0] {IDLE, REAL, DECOY} chain_t;
  localparam logic [CNT_W:0] TRIG = (CNT_W+1)'(TRIG_LIMIT);
  chain_t chain_q, chain_d;
  logic [SW-1:0] stage_q, stage_d;
  logic hit_q, hit_d;
  logic [DATA_W-1:0] hit_code_q, hit_code_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [DATA_W-1:0] word;
  logic keyed, key_ok, go_decoy, last, miss, done, genuine, suppress;
  always_comb begin
    word = '0;
    keyed = 1'b0;
    key_ok = 1'b1;
    for (int j = 0; j < DEPTH; j++) if (stage_q == SW'(j)) word = PATTERN[j*DATA_W +: DATA_W];
    for (int j = 0; j < KEY_W; j++)
      if (stage_q == SW'(j)) begin
        keyed = 1'b1;
        key_ok = key[j] == KEY_VAL[j];
      end
    go_decoy = chain_q == DECOY || (keyed && !key_ok);
    last = stage_q == SW'(DEPTH - 1);
    miss = din != word;
    done = din_vld && !miss && last;
    genuine = done && !go_decoy;
    stage_d = !din_vld ? stage_q : (miss || last) ? '0 : stage_q + 1'b1;
    chain_d = !din_vld ? chain_q : (miss || last) ? IDLE : go_decoy ? DECOY : REAL;
    hit_cnt_d = !genuine ? hit_cnt_q : (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
    suppress = TROJAN_EN && genuine && {1'b0, hit_cnt_d} >= TRIG;
    hit_d = done && !suppress;
    hit_code_d = !hit_d ? '0 : genuine ? CODE : ~CODE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      chain_q <= IDLE;
      stage_q <= '0;
      hit_q <= 1'b0;
      hit_code_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      chain_q <= chain_d;
      stage_q <= stage_d;
      hit_q <= hit_d;
      hit_code_q <= hit_code_d;
      hit_cnt_q <= hit_cnt_d;
    end
  assign hit = hit_q;
  assign hit_code = hit_code_q;
  assign stage = stage_q;
  assign in_decoy = chain_q == DECOY;
  assign hit_cnt = hit_cnt_q;
endmodule

// File: tb/tb_locked_pattern_fsm.sv
// tb_locked_pattern_fsm: directed and randomized checks against a sequence-level reference model.
module tb_locked_pattern_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_vld = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] key = 2'b10;
  logic hit;
  logic [7:0] hit_code;
  logic [2:0] stage;
  logic in_decoy;
  logic [7:0] hit_cnt;
  int checks = 0;
  int passes = 0;
  logic [7:0] pat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [1:0] key_good = 2'b10;
  int m_len = 0;
  bit m_bad = 1'b0;
  int m_cnt = 0;
  logic m_hit = 1'b0;
  logic [7:0] m_code = '0;

  locked_pattern_fsm dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .key(key),
    .hit(hit), .hit_code(hit_code), .stage(stage), .in_decoy(in_decoy), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stage"}, 32'(stage), 32'(m_len));
    chk({tag, ".in_decoy"}, 32'(in_decoy), 32'(m_bad));
    chk({tag, ".hit"}, 32'(hit), 32'(m_hit));
    chk({tag, ".hit_code"}, 32'(hit_code), 32'(m_code));
    chk({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(m_cnt));
  endtask

  // Model: a matched prefix length plus a flag that any keyed position so far saw a wrong key bit.
  task automatic model(input logic v, input logic [7:0] d, input logic [1:0] k);
    m_hit = 1'b0;
    m_code = '0;
    if (!v) return;
    if (d !== pat[m_len]) begin
      m_len = 0;
      m_bad = 1'b0;
      return;
    end
    if (m_len < 2 && k[m_len] !== key_good[m_len]) m_bad = 1'b1;
    if (m_len < 3) begin
      m_len++;
      return;
    end
    if (m_bad) begin
      m_hit = 1'b1;
      m_code = 8'hA5;
    end else begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_cnt < 5) begin
        m_hit = 1'b1;
        m_code = 8'h5A;
      end
    end
    m_len = 0;
    m_bad = 1'b0;
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic [1:0] k, input string tag);
    din_vld = v;
    din = d;
    key = k;
    @(posedge clk);
    model(v, d, k);
    #1;
    check_all(tag);
  endtask

  task automatic seq(input logic [1:0] k, input string tag);
    for (int i = 0; i < 4; i++) beat(1'b1, pat[i], k, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    m_len = 0;
    m_bad = 1'b0;
    m_cnt = 0;
    m_hit = 1'b0;
    m_code = '0;
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    seq(2'b10, "real");
    seq(2'b11, "decoy");
    beat(1'b1, 8'hA1, 2'b10, "abort_a1");
    beat(1'b1, 8'hB2, 2'b10, "abort_b2");
    beat(1'b1, 8'hFF, 2'b10, "abort_ff");
    beat(1'b1, 8'hA1, 2'b10, "reenter_a1");
    beat(1'b1, 8'hA1, 2'b10, "no_restart");
    beat(1'b1, 8'hA1, 2'b10, "restart_a1");
    beat(1'b1, 8'hB2, 2'b00, "decoy_bit1");
    beat(1'b1, 8'hC3, 2'b10, "decoy_keep");
    beat(1'b1, 8'hD4, 2'b10, "decoy_done");
    for (int n = 0; n < 5; n++) seq(2'b10, "trojan");
    do_reset("rst_clear");
    beat(1'b1, 8'hA1, 2'b10, "mid_a1");
    beat(1'b1, 8'hB2, 2'b10, "mid_b2");
    #2;
    rst = 1'b1;
    m_len = 0;
    m_bad = 1'b0;
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(1'b1, 8'hC3, 2'b10, "after_rst_c3");
    beat(1'b1, 8'hD4, 2'b10, "after_rst_d4");
    beat(1'b1, 8'hA1, 2'b10, "hold_a1");
    for (int i = 0; i < 3; i++) beat(1'b0, 8'hB2, 2'b01, "hold_idle");
    beat(1'b1, 8'hB2, 2'b10, "hold_b2");
    beat(1'b1, 8'hC3, 2'b10, "hold_c3");
    beat(1'b1, 8'hD4, 2'b10, "hold_d4");
    beat(1'b1, 8'hA1, 2'b10, "b2b_a1");
    beat(1'b1, 8'hB2, 2'b10, "b2b_b2");
    beat(1'b1, 8'hC3, 2'b11, "late_key");
    beat(1'b1, 8'hD4, 2'b11, "late_key_done");
    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      logic v;
      logic [7:0] d;
      logic [1:0] k;
      v = $urandom_range(0, 3) != 0;
      d = ($urandom_range(0, 5) != 0) ? pat[m_len] : 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
      beat(v, d, k, "rand");
    end
    for (int n = 0; n < 260; n++) seq(2'b10, "sat");
    chk("sat_cnt", 32'(hit_cnt), 32'd255);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
